// File: rtl/inst_mem_responder.sv
// rtl/inst_mem_responder.sv - Gumnut instruction-memory responder on a cyc/stb/ack fetch bus
// Optional next-word prefetch buffer: define INST_PREFETCH_EN.
module inst_mem_responder #(
  parameter int AW          = 12,
  parameter int DW          = 18,
  parameter int WAIT_STATES = 1,
  parameter     INIT_FILE   = "gasm_text.dat"
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ClkEn_e,
  input  logic          inst_cyc_i,
  input  logic          inst_stb_i,
  input  logic [11:0]   inst_adr_i,
  output logic          inst_ack_o,
  output logic [DW-1:0] inst_dat_o,
  input  logic          prog_we_i,
  input  logic [AW-1:0] prog_adr_i,
  input  logic [DW-1:0] prog_dat_i
);

  localparam int         DEPTH  = 1 << AW;
  localparam logic [2:0] WS_CNT = 3'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] adr_q, adr_d;
  logic          ack_q, ack_d;
  logic [DW-1:0] dat_q, dat_d;

  logic [DW-1:0] mem_q [DEPTH];

  // Upper fetch-address bits beyond the memory size alias onto the low words.
  logic [AW-1:0] req_adr;
  logic          req;
  logic          pf_hit;

  assign req_adr = inst_adr_i[AW-1:0];
  assign req     = inst_cyc_i && inst_stb_i;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
  end

  // Program store write port; contents deliberately survive reset.
  always @(posedge clk_i) begin
    if (ClkEn_e && prog_we_i) mem_q[prog_adr_i] <= prog_dat_i;
  end

`ifdef INST_PREFETCH_EN
  logic          pf_valid_q, pf_valid_d;
  logic [AW-1:0] pf_tag_q, pf_tag_d;
  logic [DW-1:0] pf_dat_q, pf_dat_d;
  logic [AW-1:0] nxt_adr;

  // Address arithmetic wraps naturally at DEPTH because it is AW bits wide.
  assign nxt_adr = adr_q + 1'b1;
  assign pf_hit  = pf_valid_q && (pf_tag_q == req_adr);

  // Prefetch buffer next state: fill after every ack, drop on miss or on a write to the tag.
  always_comb begin
    pf_valid_d = pf_valid_q;
    pf_tag_d   = pf_tag_q;
    pf_dat_d   = pf_dat_q;
    if (state_q == S_ACK) begin
      pf_tag_d   = nxt_adr;
      pf_dat_d   = mem_q[nxt_adr];
      // A write landing on the fill edge would leave a stale copy, so do not validate it.
      pf_valid_d = !(prog_we_i && (prog_adr_i == nxt_adr));
    end else begin
      if ((state_q == S_IDLE) && req && !pf_hit) pf_valid_d = 1'b0;
      if (prog_we_i && (prog_adr_i == pf_tag_q)) pf_valid_d = 1'b0;
    end
  end

  // Prefetch buffer registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pf_valid_q <= 1'b0;
      pf_tag_q   <= '0;
      pf_dat_q   <= '0;
    end else if (ClkEn_e) begin
      pf_valid_q <= pf_valid_d;
      pf_tag_q   <= pf_tag_d;
      pf_dat_q   <= pf_dat_d;
    end
  end
`else
  assign pf_hit = 1'b0;
`endif

  // Fetch FSM next state: request capture, wait-state countdown, one-cycle ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          adr_d = req_adr;
          cnt_d = WS_CNT;
          if (pf_hit) begin
`ifdef INST_PREFETCH_EN
            dat_d   = pf_dat_q;
`endif
            ack_d   = 1'b1;
            cnt_d   = 3'd0;
            state_d = S_ACK;
          end else if (WS_CNT == 3'd0) begin
            dat_d   = mem_q[req_adr];
            ack_d   = 1'b1;
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!inst_cyc_i) begin
          // Master abandoned the cycle: nothing is committed yet, so no ack.
          cnt_d   = 3'd0;
          state_d = S_IDLE;
        end else if (cnt_q == 3'd1) begin
          dat_d   = mem_q[adr_q];
          ack_d   = 1'b1;
          cnt_d   = 3'd0;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_ACK: begin
        // Ack is already committed; stb is not looked at here, forcing a return to IDLE.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Fetch FSM registers; reset overrides the clock enable.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      adr_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else if (ClkEn_e) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
    end
  end

  assign inst_ack_o = ack_q;
  assign inst_dat_o = dat_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// tb/tb_inst_mem_responder.sv - scoreboard bench for inst_mem_responder (WAIT_STATES 1 and 3)
module tb_inst_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n, clken, cyc, stb, we;
  logic [11:0] adr, padr;
  logic [17:0] pdat;
  logic        ack1, ack3;
  logic [17:0] dat1, dat3;

  int cycle   = 0;
  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int          cyc;
    logic [17:0] dat;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

`ifdef INST_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  inst_mem_responder #(.AW(12), .DW(18), .WAIT_STATES(1), .INIT_FILE("")) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .ClkEn_e(clken),
    .inst_cyc_i(cyc), .inst_stb_i(stb), .inst_adr_i(adr),
    .inst_ack_o(ack1), .inst_dat_o(dat1),
    .prog_we_i(we), .prog_adr_i(padr), .prog_dat_i(pdat)
  );

  inst_mem_responder #(.AW(12), .DW(18), .WAIT_STATES(3), .INIT_FILE("")) u_dut3 (
    .clk_i(clk), .rst_i(rst_n), .ClkEn_e(clken),
    .inst_cyc_i(cyc), .inst_stb_i(stb), .inst_adr_i(adr),
    .inst_ack_o(ack3), .inst_dat_o(dat3),
    .prog_we_i(we), .prog_adr_i(padr), .prog_dat_i(pdat)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cycle);
  endtask

  // Monitor: every ack must match the oldest expectation in that DUT's queue.
  always @(negedge clk) begin
    exp_t e;
    if (ack1) begin
      if (q1.size() == 0) begin
        n_total++;
        $display("FAIL ack1_unexpected: ack at cycle %0d dat 0x%0h, required none", cycle, dat1);
      end else begin
        e = q1.pop_front();
        chk("ack1_cycle", cycle, e.cyc);
        chk("ack1_dat", int'(dat1), int'(e.dat));
      end
    end
    if (ack3) begin
      if (q3.size() == 0) begin
        n_total++;
        $display("FAIL ack3_unexpected: ack at cycle %0d dat 0x%0h, required none", cycle, dat3);
      end else begin
        e = q3.pop_front();
        chk("ack3_cycle", cycle, e.cyc);
        chk("ack3_dat", int'(dat3), int'(e.dat));
      end
    end
  end

  task automatic prog_write(input logic [11:0] a, input logic [17:0] d);
    @(negedge clk);
    we = 1'b1; padr = a; pdat = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Request sampled at edge req; ack seen at edge req+WS (req on a prefetch hit), plus frozen edges.
  task automatic issue(input logic [11:0] a, input logic [17:0] e1, input logic [17:0] e3,
                       input bit hit, input int frz, input bit push);
    exp_t x;
    int   req;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = a;
    req = cycle + 1;
    if (push) begin
      x.cyc = req + (hit ? 0 : 1) + frz; x.dat = e1; q1.push_back(x);
      x.cyc = req + (hit ? 0 : 3) + frz; x.dat = e3; q3.push_back(x);
    end
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    cyc = 1'b0;
    @(negedge clk);
  endtask

  logic [11:0] ld_adr [12] = '{12'h005, 12'h010, 12'h011, 12'h020, 12'h030, 12'h040,
                               12'h100, 12'h101, 12'h200, 12'hFFF, 12'h000, 12'h001};
  logic [17:0] ld_dat [12] = '{18'h2A5A5, 18'h11111, 18'h12345, 18'h0ABCD, 18'h1C0DE, 18'h3DEAD,
                               18'h10100, 18'h20101, 18'h30200, 18'h0FFFF, 18'h3A000, 18'h00001};

  initial begin
    rst_n = 1'b0; clken = 1'b1; cyc = 1'b0; stb = 1'b0; adr = '0;
    we = 1'b0; padr = '0; pdat = '0;
    repeat (3) @(negedge clk);
    chk("reset_ack1", int'(ack1), 0);
    chk("reset_dat1", int'(dat1), 0);
    chk("reset_ack3", int'(ack3), 0);
    chk("reset_dat3", int'(dat3), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) prog_write(ld_adr[i], ld_dat[i]);

    // Basic fetch latency and data hold after ack drops.
    issue(12'h005, 18'h2A5A5, 18'h2A5A5, 1'b0, 0, 1'b1);
    repeat (4) @(negedge clk);
    chk("hold_ack1", int'(ack1), 0);
    chk("hold_dat1", int'(dat1), 'h2A5A5);
    chk("hold_dat3", int'(dat3), 'h2A5A5);
    idle(4);

    // cyc dropped one edge after the request: abort; next fetch unaffected.
    issue(12'h010, 18'h0, 18'h0, 1'b0, 0, 1'b0);
    cyc = 1'b0;
    idle(6);
    issue(12'h011, 18'h12345, 18'h12345, 1'b0, 0, 1'b1);
    idle(8);

    // Write on DUT1's capture edge: DUT1 gets the old word, DUT3 captures later and sees the new one.
    issue(12'h020, 18'h0ABCD, 18'h3FFFF, 1'b0, 0, 1'b1);
    we = 1'b1; padr = 12'h020; pdat = 18'h3FFFF;
    @(negedge clk);
    we = 1'b0;
    idle(7);
    issue(12'h020, 18'h3FFFF, 18'h3FFFF, 1'b0, 0, 1'b1);
    idle(8);

    // Clock enable low for three edges during the wait.
    issue(12'h030, 18'h1C0DE, 18'h1C0DE, 1'b0, 3, 1'b1);
    clken = 1'b0;
    repeat (3) @(negedge clk);
    clken = 1'b1;
    idle(8);

    // Reset held two cycles mid-wait: no ack, outputs cleared.
    issue(12'h040, 18'h0, 18'h0, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_ack1", int'(ack1), 0);
    chk("midrst_dat1", int'(dat1), 0);
    chk("midrst_ack3", int'(ack3), 0);
    chk("midrst_dat3", int'(dat3), 0);
    rst_n = 1'b1;
    idle(8);

    // Sequential fetches: prefetch hits are zero-wait, misses and wrap behave as documented.
    issue(12'h100, 18'h10100, 18'h10100, 1'b0, 0, 1'b1); idle(8);
    issue(12'h101, 18'h20101, 18'h20101, PF,   0, 1'b1); idle(8);
    issue(12'h200, 18'h30200, 18'h30200, 1'b0, 0, 1'b1); idle(8);
    issue(12'hFFF, 18'h0FFFF, 18'h0FFFF, 1'b0, 0, 1'b1); idle(8);
    issue(12'h000, 18'h3A000, 18'h3A000, PF,   0, 1'b1); idle(8);
    // Patching the prefetched word must force a full-latency fetch of the new value.
    prog_write(12'h001, 18'h2B001);
    issue(12'h001, 18'h2B001, 18'h2B001, 1'b0, 0, 1'b1); idle(8);

    idle(4);
    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
